timer_countdown: RTL and testbench
==================================

TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  system clock; every register updates on its rising edge.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 dados  input  4  BCD digit from the keypad encoder; valid whenever loadn is low.
REQ-005 loadn  input  1  active-low load strobe from the keypad encoder; one digit is loaded per falling edge.
REQ-006 pgt_1Hz  input  1  1 Hz timebase; one count step is taken per rising edge.
REQ-007 start  input  1  level, sampled each clock; requests countdown.
REQ-008 stop  input  1  level, sampled each clock; pauses countdown.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits MM:SS.
REQ-010 zero  output  1  high when all four digits equal 0.
REQ-011 running  output  1  high in state COUNTING.
REQ-012 done  output  1  one-cycle pulse when the count reaches 00:00 by counting.

Function
REQ-013 Load-strobe edge detection SHALL assert in the cycle where loadn==0 and its registered copy loadn_q==1.
REQ-014 Tick edge detection SHALL assert in the cycle where pgt_1Hz==1 and its registered copy tick_q==0.
REQ-015 FSM states: IDLE, COUNTING, FINISHED.
REQ-016 IDLE behaviour:
  - a load edge with dados<=9 SHALL shift the digits: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=dados.
  - start==1 with zero==0 SHALL move the FSM to COUNTING.
  - start==1 with zero==1 SHALL be ignored.
REQ-017 A load edge with dados>9 SHALL be ignored in every state.
REQ-018 COUNTING behaviour:
  - load edges SHALL be ignored.
  - each tick edge SHALL decrement MM:SS by one second.
  - stop==1 SHALL return the FSM to IDLE with the digits held (pause).
REQ-019 Decrement rule:
  - sec_ones>0: sec_ones-1.
  - sec_ones==0, sec_tens>0: sec_ones=9, sec_tens-1.
  - both seconds digits 0: sec_ones=9, sec_tens=5, and minutes borrow with the same rule (min_ones 0 -> 9, min_tens-1).
REQ-020 Entered sec_tens values 6..9 SHALL count down without normalisation (e.g. 00:90 -> 00:89).
REQ-021 A decrement from 00:01 SHALL leave 00:00, move the FSM to FINISHED, and assert done in the following cycle only.
REQ-022 00:00 SHALL never be decremented; the FSM SHALL never wrap to 99:59.
REQ-023 stop and a tick edge in the same cycle: stop wins, no decrement.
REQ-024 start and stop both high: stop wins; in IDLE the FSM SHALL remain in IDLE.
REQ-025 FINISHED behaviour:
  - digits held at 00:00.
  - a valid load edge SHALL shift the digit in and move the FSM to IDLE.
  - start SHALL be ignored.
REQ-026 Outputs zero and running SHALL be combinational decodes of the registered digits and state; all digit updates SHALL be visible one clock after the qualifying edge.

Reset
REQ-027 clear==1 at a rising clock edge SHALL force:
  - all digits 0, state IDLE, done 0, running 0, zero 1;
  - loadn_q 0 and tick_q 1, so an input already low or high at release produces no spurious edge.
REQ-028 clear SHALL have priority over every other input, including mid-countdown.

Structure
REQ-029 Package timer_pkg SHALL hold the FSM state enumeration, the BCD constants MAX_DIGIT=9 and MAX_SEC_TENS=5, and a 4-digit MM:SS record type.
REQ-030 Sub-module mmss_decrement (combinational, MM:SS in -> MM:SS out plus an is_zero flag) SHALL implement REQ-019, REQ-020 and REQ-022.
REQ-031 Edge detectors and the FSM SHALL reside in timer_countdown.

Verification
REQ-032 Load sequence: load edges with dados 1,2,3,0 -> display 12:30, zero=0, state IDLE.
REQ-033 Invalid digit: load edge with dados=4'hA after 12:30 -> display unchanged at 12:30.
REQ-034 Borrow chain: start from 01:00, one tick -> 00:59, running=1; from 10:00, one tick -> 09:59.
REQ-035 Terminal count: start at 00:02, two ticks -> 00:00, FSM in FINISHED, done high exactly one cycle, a third tick leaves 00:00.
REQ-036 Pause and conflicts:
  - stop coincident with a tick at 00:05 -> digits stay 00:05, state IDLE.
  - a later start resumes counting to 00:04 on the next tick.
  - a load edge during COUNTING is ignored.
REQ-037 Reset mid-run: clear during COUNTING at 03:17 -> next cycle 00:00, IDLE, zero=1.
  - holding loadn low and pgt_1Hz high through clear release -> no shift and no decrement.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Holds the FSM states, BCD limits and the four-digit display record.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    function automatic logic mmss_is_zero(input mmss_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/mmss_decrement.sv
// Combinational one-second decrement of an MM:SS value.
// 00:00 passes through unchanged so the count never wraps to 99:59.
module mmss_decrement
    import timer_pkg::*;
(
    input  mmss_t i_time,
    output mmss_t o_time,
    output logic  o_is_zero
);

    assign o_is_zero = mmss_is_zero(i_time);

    // Borrow ripples from seconds ones up through the minutes.
    // Seconds tens above 5 are not normalised; they simply count down.
    always_comb begin
        o_time = i_time;
        if (!o_is_zero) begin
            if (i_time.sec_ones != 4'd0) begin
                o_time.sec_ones = i_time.sec_ones - 4'd1;
            end else if (i_time.sec_tens != 4'd0) begin
                o_time.sec_ones = MAX_DIGIT;
                o_time.sec_tens = i_time.sec_tens - 4'd1;
            end else begin
                o_time.sec_ones = MAX_DIGIT;
                o_time.sec_tens = MAX_SEC_TENS;
                if (i_time.min_ones != 4'd0) begin
                    o_time.min_ones = i_time.min_ones - 4'd1;
                end else begin
                    o_time.min_ones = MAX_DIGIT;
                    o_time.min_tens = i_time.min_tens - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// Keypad-loaded MM:SS countdown timer with 1 Hz timebase.
// Edge detectors, digit register and control FSM live here.
module timer_countdown
    import timer_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] dados,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       running,
    output logic       done
);

    mmss_t  r_digits;
    state_t r_state;
    logic   r_done;
    logic   r_loadn_q;
    logic   r_tick_q;

    mmss_t  w_dec;
    mmss_t  w_shifted;
    logic   w_zero;
    logic   w_load_edge;
    logic   w_tick_edge;
    logic   w_load_ok;
    logic   w_dec_zero;

    mmss_decrement u_dec (
        .i_time    (r_digits),
        .o_time    (w_dec),
        .o_is_zero (w_zero)
    );

    assign w_load_edge = !loadn && r_loadn_q;
    assign w_tick_edge = pgt_1Hz && !r_tick_q;
    assign w_load_ok   = w_load_edge && (dados <= MAX_DIGIT);
    assign w_dec_zero  = mmss_is_zero(w_dec);
    assign w_shifted   = {r_digits.min_ones, r_digits.sec_tens,
                          r_digits.sec_ones, dados};

    // Edge-detect history, digit register and control FSM.
    // Stop outranks both start and a coincident tick.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_digits  <= '0;
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_loadn_q <= 1'b0;
            r_tick_q  <= 1'b1;
        end else begin
            r_loadn_q <= loadn;
            r_tick_q  <= pgt_1Hz;
            r_done    <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_load_ok) begin
                        r_digits <= w_shifted;
                    end
                    if (start && !stop && !w_zero) begin
                        r_state <= ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick_edge && !w_zero) begin
                        r_digits <= w_dec;
                        if (w_dec_zero) begin
                            r_state <= ST_FINISHED;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_FINISHED: begin
                    if (w_load_ok) begin
                        r_digits <= w_shifted;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign min_tens = r_digits.min_tens;
    assign min_ones = r_digits.min_ones;
    assign sec_tens = r_digits.sec_tens;
    assign sec_ones = r_digits.sec_ones;
    assign zero     = w_zero;
    assign running  = (r_state == ST_COUNTING);
    assign done     = r_done;

endmodule

// File: tb/tb_timer_countdown.sv
// Testbench for timer_countdown: directed scenarios plus random stimulus.
// Expected outputs come from a decimal-arithmetic model of the timer.
module tb_timer_countdown;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] dados = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       zero, running, done;

    timer_countdown dut (
        .clock    (clock),
        .clear    (clear),
        .dados    (dados),
        .loadn    (loadn),
        .pgt_1Hz  (pgt_1Hz),
        .start    (start),
        .stop     (stop),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .running  (running),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] digits;
        logic        zero;
        logic        running;
        logic        done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    string cur_tag = "reset";

    int checks = 0;
    int errors = 0;

    // Reference model: the display is a 4-digit decimal number N = MM*100+SS.
    localparam int M_IDLE = 0;
    localparam int M_COUNT = 1;
    localparam int M_FIN = 2;
    int m_n = 0;
    int m_mode = M_IDLE;
    bit m_done = 0;
    bit m_prev_loadn = 0;
    bit m_prev_tick = 1;

    task automatic model_step();
        bit le, te, ok;
        int mm, ss, old_n;
        if (clear) begin
            m_n = 0;
            m_mode = M_IDLE;
            m_done = 0;
            m_prev_loadn = 0;
            m_prev_tick = 1;
            return;
        end
        le = !loadn && m_prev_loadn;
        te = pgt_1Hz && !m_prev_tick;
        ok = le && (int'(dados) <= 9);
        old_n = m_n;
        m_done = 0;
        if (m_mode == M_IDLE) begin
            if (ok) m_n = (m_n % 1000) * 10 + int'(dados);
            if (start && !stop && old_n != 0) m_mode = M_COUNT;
        end else if (m_mode == M_COUNT) begin
            if (stop) begin
                m_mode = M_IDLE;
            end else if (te && m_n != 0) begin
                mm = m_n / 100;
                ss = m_n % 100;
                if (ss > 0) ss = ss - 1;
                else begin
                    ss = 59;
                    mm = mm - 1;
                end
                m_n = mm * 100 + ss;
                if (m_n == 0) begin
                    m_mode = M_FIN;
                    m_done = 1;
                end
            end
        end else begin
            if (ok) begin
                m_n = (m_n % 1000) * 10 + int'(dados);
                m_mode = M_IDLE;
            end
        end
        m_prev_loadn = loadn;
        m_prev_tick = pgt_1Hz;
    endtask

    function automatic logic [15:0] to_digits(input int n);
        logic [3:0] a, b, c, d;
        a = 4'((n / 1000) % 10);
        b = 4'((n / 100) % 10);
        c = 4'((n / 10) % 10);
        d = 4'(n % 10);
        return {a, b, c, d};
    endfunction

    // One clock: model follows the inputs sampled at the edge, expectation queued.
    task automatic cyc();
        exp_t e;
        @(posedge clock);
        model_step();
        e.digits  = to_digits(m_n);
        e.zero    = (m_n == 0);
        e.running = (m_mode == M_COUNT);
        e.done    = m_done;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
        @(negedge clock);
    endtask

    task automatic load_digit(input logic [3:0] d);
        dados = d;
        loadn = 1'b0;
        cyc();
        loadn = 1'b1;
        cyc();
    endtask

    task automatic tick();
        pgt_1Hz = 1'b1;
        cyc();
        pgt_1Hz = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
    endtask

    task automatic load4(input logic [3:0] a, b, c, d);
        load_digit(a);
        load_digit(b);
        load_digit(c);
        load_digit(d);
    endtask

    // Monitor: every clock the DUT presents a display; compare against the queue.
    always @(posedge clock) begin
        exp_t e;
        string t;
        logic [15:0] got;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones};
            checks++;
            if (got !== e.digits || zero !== e.zero ||
                running !== e.running || done !== e.done) begin
                errors++;
                $display("FAIL %s: got %h z=%b r=%b d=%b, expected %h z=%b r=%b d=%b",
                         t, got, zero, running, done,
                         e.digits, e.zero, e.running, e.done);
            end
        end
    end

    initial begin
        @(negedge clock);
        cur_tag = "reset";
        clear = 1'b1;
        cyc();
        cyc();
        clear = 1'b0;
        cyc();

        cur_tag = "load_1230";
        load4(4'd1, 4'd2, 4'd3, 4'd0);
        cur_tag = "invalid_digit";
        load_digit(4'hA);
        load_digit(4'hF);
        cur_tag = "start_zero_ignored";
        do_clear();
        do_start();

        cur_tag = "borrow_0100";
        load4(4'd0, 4'd1, 4'd0, 4'd0);
        do_start();
        tick();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cur_tag = "borrow_1000";
        do_clear();
        load4(4'd1, 4'd0, 4'd0, 4'd0);
        do_start();
        tick();
        tick();
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        cur_tag = "unnormalised_0090";
        do_clear();
        load4(4'd0, 4'd0, 4'd9, 4'd0);
        do_start();
        tick();
        tick();
        cur_tag = "start_stop_conflict";
        stop = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        stop = 1'b0;
        cyc();

        cur_tag = "terminal_0002";
        do_clear();
        load4(4'd0, 4'd0, 4'd0, 4'd2);
        do_start();
        tick();
        tick();
        cur_tag = "no_wrap_after_zero";
        tick();
        do_start();
        tick();
        cur_tag = "finished_load";
        load_digit(4'hC);
        load_digit(4'd3);
        do_start();
        tick();
        tick();
        tick();

        cur_tag = "pause_0005";
        do_clear();
        load4(4'd0, 4'd0, 4'd0, 4'd6);
        do_start();
        tick();
        stop = 1'b1;
        pgt_1Hz = 1'b1;
        cyc();
        stop = 1'b0;
        pgt_1Hz = 1'b0;
        cyc();
        tick();
        cur_tag = "resume_0004";
        do_start();
        tick();
        cur_tag = "load_during_count";
        load_digit(4'd7);
        tick();

        cur_tag = "clear_mid_run";
        do_clear();
        load4(4'd0, 4'd3, 4'd1, 4'd8);
        do_start();
        tick();
        clear = 1'b1;
        loadn = 1'b0;
        pgt_1Hz = 1'b1;
        cyc();
        clear = 1'b0;
        cur_tag = "held_inputs_release";
        cyc();
        cyc();
        loadn = 1'b1;
        pgt_1Hz = 1'b0;
        cyc();

        cur_tag = "random";
        for (int i = 0; i < 800; i++) begin
            clear   = ($urandom_range(0, 79) == 0);
            dados   = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
            loadn   = ($urandom_range(0, 3) != 0);
            pgt_1Hz = ($urandom_range(0, 1) == 1);
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            cyc();
        end
        clear = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loadn = 1'b1;
        pgt_1Hz = 1'b0;

        @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
